pipe_decode_ctrl: RTL and testbench

Registered, handshaked successor to the combinational decode controller. It decodes opcode/func for R-type, immediate, load/store, branch and multiply/divide instructions into ALU and datapath controls. It sits between the IF/ID register and the EX stage as the control half of the ID/EX register, with valid/ready flow control, flush, and a multi-cycle HI/LO interlock. Forwarding and load-use hazards remain outside this block.

---
 rtl/pipe_decode_ctrl_if.sv | 40 ++++
 rtl/pipe_decode_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pipe_decode_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_decode_ctrl_if.sv
// Handshake bundles around the decode control stage: IF/ID side and EX side.
interface pipe_decode_ctrl_id_if;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] opcode;
  logic [5:0] func;

  modport master (output in_valid, opcode, func, input in_ready);
  modport slave  (input in_valid, opcode, func, output in_ready);
endinterface

interface pipe_decode_ctrl_ex_if #(parameter int ALUOP_W = 4);
  logic               out_valid;
  logic               ex_stall;
  logic [ALUOP_W-1:0] aluop;
  logic               alusrc;
  logic               regdst;
  logic               regwrite;
  logic               writemem;
  logic               readmem;
  logic               memtoreg;
  logic               shift;
  logic               branch;
  logic               md_start;
  logic               md_busy;
  logic               illegal;

  modport master (
    output out_valid, aluop, alusrc, regdst, regwrite,
    output writemem, readmem, memtoreg, shift, branch,
    output md_start, md_busy, illegal,
    input  ex_stall
  );
  modport slave (
    input  out_valid, aluop, alusrc, regdst, regwrite,
    input  writemem, readmem, memtoreg, shift, branch,
    input  md_start, md_busy, illegal,
    output ex_stall
  );
endinterface

// File: rtl/pipe_decode_ctrl.sv
// Registered decode controller (control half of ID/EX) with HI/LO interlock.
// Define CTRL_MULDIV_EN to enable MULT/DIV/MFHI/MFLO and the busy counter.
module pipe_decode_ctrl #(
  parameter int ALUOP_W   = 4,
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  pipe_decode_ctrl_id_if.slave  id,
  pipe_decode_ctrl_ex_if.master ex
);

  if (MD_CYCLES < 1 || MD_CYCLES > 255 ||
      MD_CYCLES >= (1 << CNT_W)) begin : g_cfg_err
    $error("pipe_decode_ctrl: MD_CYCLES does not fit CNT_W");
  end

  localparam logic [ALUOP_W-1:0] A_NOP  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] A_ADD  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] A_ADDU = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] A_SUB  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] A_SUBU = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] A_AND  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] A_OR   = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] A_NOR  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] A_SLT  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] A_SLL  = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] A_SRL  = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] A_SRA  = ALUOP_W'(11);

  typedef struct packed {
    logic [ALUOP_W-1:0] aluop;
    logic alusrc;
    logic regdst;
    logic regwrite;
    logic writemem;
    logic readmem;
    logic memtoreg;
    logic shift;
    logic branch;
    logic illegal;
  } ctrl_t;

  ctrl_t dec;
  ctrl_t held;
  logic  out_valid;
  logic  md_block;
  logic  cap;
  logic  xfer;

`ifdef CTRL_MULDIV_EN
  logic md_cls;
  logic mf_cls;
`endif

  always_comb begin
    dec = '0;
`ifdef CTRL_MULDIV_EN
    md_cls = 1'b0;
    mf_cls = 1'b0;
`endif
    unique case (id.opcode)
      6'h00: begin
        dec.regdst   = 1'b1;
        dec.regwrite = 1'b1;
        unique case (id.func)
          6'h20: dec.aluop = A_ADD;
          6'h21: dec.aluop = A_ADDU;
          6'h22: dec.aluop = A_SUB;
          6'h23: dec.aluop = A_SUBU;
          6'h24: dec.aluop = A_AND;
          6'h25: dec.aluop = A_OR;
          6'h27: dec.aluop = A_NOR;
          6'h2A: dec.aluop = A_SLT;
          6'h00: begin dec.aluop = A_SLL; dec.shift = 1'b1; end
          6'h02: begin dec.aluop = A_SRL; dec.shift = 1'b1; end
          6'h03: begin dec.aluop = A_SRA; dec.shift = 1'b1; end
`ifdef CTRL_MULDIV_EN
          6'h10, 6'h12: mf_cls = 1'b1;
          6'h18, 6'h1A: begin
            dec.regdst   = 1'b0;
            dec.regwrite = 1'b0;
            md_cls       = 1'b1;
          end
`endif
          default: begin
            dec         = '0;
            dec.illegal = 1'b1;
          end
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        unique case (id.opcode[2:0])
          3'h0:    dec.aluop = A_ADD;
          3'h1:    dec.aluop = A_ADDU;
          3'h2:    dec.aluop = A_SLT;
          3'h4:    dec.aluop = A_AND;
          default: dec.aluop = A_OR;
        endcase
      end
      6'h23: begin
        dec.aluop    = A_ADD;
        dec.alusrc   = 1'b1;
        dec.readmem  = 1'b1;
        dec.memtoreg = 1'b1;
        dec.regwrite = 1'b1;
      end
      6'h2B: begin
        dec.aluop    = A_ADD;
        dec.alusrc   = 1'b1;
        dec.writemem = 1'b1;
      end
      6'h04: begin
        dec.aluop  = A_SUB;
        dec.branch = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign xfer = out_valid && !ex.ex_stall;
  assign id.in_ready = !flush && (!out_valid || !ex.ex_stall) && !md_block;
  assign cap = id.in_valid && id.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      held      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      held      <= '0;
    end else if (cap) begin
      out_valid <= 1'b1;
      held      <= dec;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

`ifdef CTRL_MULDIV_EN
  logic             md_held;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      md_held <= 1'b0;
    else if (flush)
      md_held <= 1'b0;
    else if (cap)
      md_held <= md_cls;
  end

  // Counter keeps running through flushes once an issue has happened.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (ex.md_start)
      cnt <= CNT_W'(MD_CYCLES);
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign ex.md_start = xfer && md_held && !flush;
  assign ex.md_busy  = (cnt != '0);
  assign md_block    = ex.md_busy && (md_cls || mf_cls);
`else
  assign ex.md_start = 1'b0;
  assign ex.md_busy  = 1'b0;
  assign md_block    = 1'b0;
`endif

  assign ex.out_valid = out_valid;
  assign ex.aluop     = held.aluop;
  assign ex.alusrc    = held.alusrc;
  assign ex.regdst    = held.regdst;
  assign ex.regwrite  = held.regwrite;
  assign ex.writemem  = held.writemem;
  assign ex.readmem   = held.readmem;
  assign ex.memtoreg  = held.memtoreg;
  assign ex.shift     = held.shift;
  assign ex.branch    = held.branch;
  assign ex.illegal   = held.illegal;

endmodule

// File: tb/tb_pipe_decode_ctrl.sv
// Directed bench for pipe_decode_ctrl (MD_CYCLES=4).
// Covers both CTRL_MULDIV_EN builds.
module tb_pipe_decode_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   npass = 0;
  int   nfail = 0;
  int   ntot  = 0;

  always #5 clk = ~clk;

  pipe_decode_ctrl_id_if id_bus ();
  pipe_decode_ctrl_ex_if #(.ALUOP_W(4)) ex_bus ();

  pipe_decode_ctrl #(
    .ALUOP_W  (4),
    .MD_CYCLES(4),
    .CNT_W    (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .id   (id_bus),
    .ex   (ex_bus)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op,
                       input logic [5:0] fn);
    id_bus.in_valid = v;
    id_bus.opcode   = op;
    id_bus.func     = fn;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    ex_bus.ex_stall = 1'b0;
    drive(1'b0, 6'h00, 6'h00);
    repeat (2) tick();
    chk("rst_out_valid", {7'd0, ex_bus.out_valid}, 8'd0);
    chk("rst_aluop", {4'd0, ex_bus.aluop}, 8'd0);
    chk("rst_regwrite", {7'd0, ex_bus.regwrite}, 8'd0);
    chk("rst_illegal", {7'd0, ex_bus.illegal}, 8'd0);
    chk("rst_md_busy", {7'd0, ex_bus.md_busy}, 8'd0);
    chk("rst_md_start", {7'd0, ex_bus.md_start}, 8'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {7'd0, id_bus.in_ready}, 8'd1);

    // ADD
    drive(1'b1, 6'h00, 6'h20);
    tick();
    chk("add_valid", {7'd0, ex_bus.out_valid}, 8'd1);
    chk("add_aluop", {4'd0, ex_bus.aluop}, 8'd1);
    chk("add_regdst", {7'd0, ex_bus.regdst}, 8'd1);
    chk("add_regwrite", {7'd0, ex_bus.regwrite}, 8'd1);
    chk("add_alusrc", {7'd0, ex_bus.alusrc}, 8'd0);
    chk("add_illegal", {7'd0, ex_bus.illegal}, 8'd0);

    // LW then SW back-to-back
    drive(1'b1, 6'h23, 6'h00);
    chk("lw_in_ready", {7'd0, id_bus.in_ready}, 8'd1);
    tick();
    chk("lw_readmem", {7'd0, ex_bus.readmem}, 8'd1);
    chk("lw_memtoreg", {7'd0, ex_bus.memtoreg}, 8'd1);
    chk("lw_regwrite", {7'd0, ex_bus.regwrite}, 8'd1);
    chk("lw_alusrc", {7'd0, ex_bus.alusrc}, 8'd1);
    drive(1'b1, 6'h2B, 6'h00);
    chk("sw_in_ready", {7'd0, id_bus.in_ready}, 8'd1);
    tick();
    chk("sw_valid", {7'd0, ex_bus.out_valid}, 8'd1);
    chk("sw_writemem", {7'd0, ex_bus.writemem}, 8'd1);
    chk("sw_regwrite", {7'd0, ex_bus.regwrite}, 8'd0);
    chk("sw_aluop", {4'd0, ex_bus.aluop}, 8'd1);

    // ORI under a 3-cycle stall, SLL waiting behind it
    drive(1'b1, 6'h0D, 6'h00);
    tick();
    ex_bus.ex_stall = 1'b1;
    drive(1'b1, 6'h00, 6'h00);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ori_stall_ready", {7'd0, id_bus.in_ready}, 8'd0);
      chk("ori_stall_aluop", {4'd0, ex_bus.aluop}, 8'd6);
      chk("ori_stall_alusrc", {7'd0, ex_bus.alusrc}, 8'd1);
      chk("ori_stall_valid", {7'd0, ex_bus.out_valid}, 8'd1);
      tick();
    end
    ex_bus.ex_stall = 1'b0;
    #1;
    chk("sll_in_ready", {7'd0, id_bus.in_ready}, 8'd1);
    tick();
    chk("sll_aluop", {4'd0, ex_bus.aluop}, 8'd9);
    chk("sll_shift", {7'd0, ex_bus.shift}, 8'd1);

    // BEQ presented with flush: squash SLL, no capture
    drive(1'b1, 6'h04, 6'h00);
    flush = 1'b1;
    ex_bus.ex_stall = 1'b1;
    #1;
    chk("flush_in_ready", {7'd0, id_bus.in_ready}, 8'd0);
    tick();
    flush = 1'b0;
    ex_bus.ex_stall = 1'b0;
    chk("flush_valid", {7'd0, ex_bus.out_valid}, 8'd0);
    drive(1'b0, 6'h04, 6'h00);
    tick();
    chk("flush_no_cap", {7'd0, ex_bus.out_valid}, 8'd0);
    drive(1'b1, 6'h04, 6'h00);
    tick();
    chk("beq_branch", {7'd0, ex_bus.branch}, 8'd1);
    chk("beq_aluop", {4'd0, ex_bus.aluop}, 8'd3);
    chk("beq_regwrite", {7'd0, ex_bus.regwrite}, 8'd0);
    drive(1'b0, 6'h00, 6'h00);
    tick();
    chk("beq_drain", {7'd0, ex_bus.out_valid}, 8'd0);

    // MULT then MFLO
    drive(1'b1, 6'h00, 6'h18);
    tick();
    drive(1'b0, 6'h00, 6'h00);
    #1;
`ifdef CTRL_MULDIV_EN
    chk("mult_regwrite", {7'd0, ex_bus.regwrite}, 8'd0);
    chk("mult_illegal", {7'd0, ex_bus.illegal}, 8'd0);
    chk("mult_md_start", {7'd0, ex_bus.md_start}, 8'd1);
    chk("mult_busy_pre", {7'd0, ex_bus.md_busy}, 8'd0);
    tick();
    chk("mult_start_end", {7'd0, ex_bus.md_start}, 8'd0);
    drive(1'b1, 6'h00, 6'h12);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("md_busy_hi", {7'd0, ex_bus.md_busy}, 8'd1);
      chk("mflo_blocked", {7'd0, id_bus.in_ready}, 8'd0);
      chk("mflo_no_cap", {7'd0, ex_bus.out_valid}, 8'd0);
      tick();
    end
    chk("md_busy_lo", {7'd0, ex_bus.md_busy}, 8'd0);
    chk("mflo_ready", {7'd0, id_bus.in_ready}, 8'd1);
    tick();
    drive(1'b0, 6'h00, 6'h00);
    chk("mflo_valid", {7'd0, ex_bus.out_valid}, 8'd1);
    chk("mflo_regwrite", {7'd0, ex_bus.regwrite}, 8'd1);
    chk("mflo_regdst", {7'd0, ex_bus.regdst}, 8'd1);
    chk("mflo_aluop", {4'd0, ex_bus.aluop}, 8'd0);
    chk("mflo_md_start", {7'd0, ex_bus.md_start}, 8'd0);
    tick();
`else
    chk("mult_illegal", {7'd0, ex_bus.illegal}, 8'd1);
    chk("mult_regwrite", {7'd0, ex_bus.regwrite}, 8'd0);
    chk("mult_aluop", {4'd0, ex_bus.aluop}, 8'd0);
    chk("mult_md_start", {7'd0, ex_bus.md_start}, 8'd0);
    tick();
    chk("mult_md_busy", {7'd0, ex_bus.md_busy}, 8'd0);
`endif

    // MULT issued, 0x3F captured and stalled, then async reset
    drive(1'b1, 6'h00, 6'h18);
    tick();
    drive(1'b1, 6'h3F, 6'h00);
    tick();
    drive(1'b0, 6'h00, 6'h00);
    chk("ill_illegal", {7'd0, ex_bus.illegal}, 8'd1);
    chk("ill_regwrite", {7'd0, ex_bus.regwrite}, 8'd0);
    chk("ill_aluop", {4'd0, ex_bus.aluop}, 8'd0);
`ifdef CTRL_MULDIV_EN
    chk("ill_busy", {7'd0, ex_bus.md_busy}, 8'd1);
`endif
    ex_bus.ex_stall = 1'b1;
    tick();
    chk("ill_stall_hold", {7'd0, ex_bus.illegal}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2_valid", {7'd0, ex_bus.out_valid}, 8'd0);
    chk("rst2_illegal", {7'd0, ex_bus.illegal}, 8'd0);
    chk("rst2_busy", {7'd0, ex_bus.md_busy}, 8'd0);
    chk("rst2_aluop", {4'd0, ex_bus.aluop}, 8'd0);
    tick();
    rst_n = 1'b1;
    ex_bus.ex_stall = 1'b0;
    #1;
    chk("rst2_in_ready", {7'd0, id_bus.in_ready}, 8'd1);
    chk("rst2_busy_after", {7'd0, ex_bus.md_busy}, 8'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
